// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared key-path types and 50 MHz default cycle constants,
//               used by the debouncer and the gesture decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

    localparam int c_debounce_cyc = 1_000_000;
    localparam int c_long_cyc     = 50_000_000;
    localparam int c_dclk_cyc     = 15_000_000;
    localparam int c_cnt_w        = 26;

    // One-hot gesture states
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_PRESSED   = 5'b00010,
        ST_LONG_HELD = 5'b00100,
        ST_WAIT2     = 5'b01000,
        ST_PRESSED2  = 5'b10000
    } key_state_e;

endpackage

`default_nettype wire

// File: rtl/key_gesture_timer.sv
// ============================================================================
// Module      : key_gesture_timer
// Description : Gesture timer with clear/enable and terminal-count flags for
//               the long-press and double-click windows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_gesture_timer
    import key_pkg::*;
#(
    parameter int CNT_W    = c_cnt_w,
    parameter int LONG_CYC = c_long_cyc,
    parameter int DCLK_CYC = c_dclk_cyc
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_long_hit,
    output logic o_dclk_hit
);

    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_dclk_last = CNT_W'(DCLK_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority so a state change always restarts the count at zero
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_long_hit = (r_cnt == c_long_last);
    assign o_dclk_hit = (r_cnt == c_dclk_last);

endmodule

`default_nettype wire

// File: rtl/key_event_decoder.sv
// ============================================================================
// Module      : key_event_decoder
// Description : Classifies debounced key gestures into short press, long press
//               and double click pulses. Double click enabled by KEY_DCLICK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_decoder
    import key_pkg::*;
#(
    parameter int LONG_CYC = c_long_cyc,
    parameter int DCLK_CYC = c_dclk_cyc,
    parameter int CNT_W    = c_cnt_w
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    key_state_e r_state;
    key_state_e w_next;

    logic w_press;
    logic w_release;
    logic w_long_hit;
    logic w_dclk_hit;
    logic w_timer_en;
    logic w_timer_clr;
    logic w_short;
    logic w_long;
    logic w_dbl;
    logic r_short;
    logic r_long;

    assign w_press     = key_flag & ~key_state;
    assign w_release   = key_flag &  key_state;
    assign w_timer_en  = (r_state == ST_PRESSED) || (r_state == ST_WAIT2) ||
                         (r_state == ST_PRESSED2);
    assign w_timer_clr = (w_next != r_state);

    key_gesture_timer #(
        .CNT_W    (CNT_W),
        .LONG_CYC (LONG_CYC),
        .DCLK_CYC (DCLK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_timer_clr),
        .i_en       (w_timer_en),
        .o_long_hit (w_long_hit),
        .o_dclk_hit (w_dclk_hit)
    );

    // Key events are tested before timeouts so an event on the terminal cycle wins
    always_comb begin
        w_next  = r_state;
        w_short = 1'b0;
        w_long  = 1'b0;
        w_dbl   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) w_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (w_release) begin
`ifdef KEY_DCLICK_EN
                    w_next  = ST_WAIT2;
`else
                    w_short = 1'b1;
                    w_next  = ST_IDLE;
`endif
                end else if (w_long_hit) begin
                    w_long = 1'b1;
                    w_next = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (w_release) w_next = ST_IDLE;
            end
`ifdef KEY_DCLICK_EN
            ST_WAIT2: begin
                if (w_press) begin
                    w_next = ST_PRESSED2;
                end else if (w_dclk_hit) begin
                    w_short = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_PRESSED2: begin
                if (w_release) begin
                    w_dbl  = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_long_hit) begin
                    w_long = 1'b1;
                    w_next = ST_LONG_HELD;
                end
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_short <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_short <= w_short;
            r_long  <= w_long;
        end
    end

`ifdef KEY_DCLICK_EN
    logic r_dbl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbl <= 1'b0;
        end else begin
            r_dbl <= w_dbl;
        end
    end

    assign double_click = r_dbl;
`else
    logic w_unused_dclk;

    assign w_unused_dclk = w_dclk_hit | w_dbl;
    assign double_click  = 1'b0;
`endif

    assign short_press = r_short;
    assign long_press  = r_long;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_key_event_decoder.sv
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Scoreboard bench for key_event_decoder (LONG=100, DCLK=30);
//               expectations follow KEY_DCLICK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_decoder;

    localparam int c_long = 100;
    localparam int c_dclk = 30;
    localparam int c_p_short = 1;
    localparam int c_p_long  = 2;
    localparam int c_p_dbl   = 4;

    typedef struct {
        int    cyc;
        int    pulses;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_state;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];

    key_event_decoder #(
        .LONG_CYC (c_long),
        .DCLK_CYC (c_dclk),
        .CNT_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pulses();
        return {29'd0, double_click, long_press, short_press};
    endfunction

    task automatic expect_pulse(input int at, input int p, input string tag);
        exp_t e;
        e.cyc = at;
        e.pulses = p;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Drives one key event, sampled at the edge that makes cyc == at
    task automatic evt_at(input logic lvl, input int at);
        while (cyc < at - 1) @(negedge clk);
        key_flag  = 1'b1;
        key_state = lvl;
        @(negedge clk);
        key_flag  = 1'b0;
    endtask

    task automatic wait_to(input int at);
        while (cyc < at) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check(e.tag, pulses(), e.pulses);
            end else if (pulses() != 0) begin
                check("spurious_pulse", pulses(), 0);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int r;
        int p;
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pulses", pulses(), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Long hold: one pulse 100 cycles after press, silent release
        e = cyc + 2;
        expect_pulse(e + c_long, c_p_long, "long_hold");
        evt_at(1'b0, e);
        check("busy_pressed", busy, 1);
        wait_to(e + 120);
        check("busy_long_held", busy, 1);
        evt_at(1'b1, e + 150);
        check("busy_after_long", busy, 0);
        wait_to(cyc + 40);

        // Reset mid-press aborts the gesture
        e = cyc + 2;
        evt_at(1'b0, e);
        wait_to(e + 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pulses", pulses(), 0);
        evt_at(1'b1, cyc + 5);
        wait_to(cyc + 40);
        check("rst_mid_idle", busy, 0);

        // Release while idle is ignored
        evt_at(1'b1, cyc + 2);
        check("idle_release_busy", busy, 0);
        wait_to(cyc + 5);

`ifdef KEY_DCLICK_EN
        // Short press reported after the double-click window closes
        e = cyc + 2;
        r = e + 20;
        expect_pulse(r + c_dclk, c_p_short, "short_delayed");
        evt_at(1'b0, e);
        evt_at(1'b1, r);
        wait_to(r + c_dclk - 1);
        check("busy_wait2", busy, 1);
        wait_to(r + c_dclk);
        check("busy_after_short", busy, 0);
        wait_to(cyc + 5);

        // Double click
        e = cyc + 2;
        r = e + 10;
        p = r + 10;
        expect_pulse(p + 10, c_p_dbl, "double_click");
        evt_at(1'b0, e);
        evt_at(1'b1, r);
        evt_at(1'b0, p);
        evt_at(1'b1, p + 10);
        check("busy_after_dbl", busy, 0);
        wait_to(cyc + 40);

        // Release on the last hold cycle, second press on the last window cycle
        e = cyc + 2;
        r = e + c_long;
        p = r + c_dclk;
        expect_pulse(p + 5, c_p_dbl, "boundary_dbl");
        evt_at(1'b0, e);
        evt_at(1'b1, r);
        evt_at(1'b0, p);
        check("busy_pressed2", busy, 1);
        evt_at(1'b1, p + 5);
        wait_to(cyc + 40);

        // Long hold on the second press discards the first click
        e = cyc + 2;
        p = e + 20;
        expect_pulse(p + c_long, c_p_long, "long_in_pressed2");
        evt_at(1'b0, e);
        evt_at(1'b1, e + 10);
        evt_at(1'b0, p);
        evt_at(1'b1, p + 130);
        wait_to(cyc + 40);
`else
        // Short press reported the cycle after release
        e = cyc + 2;
        r = e + 20;
        expect_pulse(r, c_p_short, "short_immediate");
        evt_at(1'b0, e);
        evt_at(1'b1, r);
        check("busy_after_short", busy, 0);
        wait_to(cyc + 5);

        // Release on the last hold cycle is still short
        e = cyc + 2;
        expect_pulse(e + c_long, c_p_short, "short_at_boundary");
        evt_at(1'b0, e);
        evt_at(1'b1, e + c_long);
        wait_to(cyc + 5);

        // One cycle later it is long, with no short afterwards
        e = cyc + 2;
        expect_pulse(e + c_long, c_p_long, "long_at_boundary");
        evt_at(1'b0, e);
        evt_at(1'b1, e + c_long + 1);
        wait_to(cyc + 5);

        // Duplicate press does not restart the gesture
        e = cyc + 2;
        expect_pulse(e + 20, c_p_short, "short_dup_press");
        evt_at(1'b0, e);
        evt_at(1'b0, e + 5);
        evt_at(1'b1, e + 20);
        wait_to(cyc + 5);

        // Minimum one-cycle press
        e = cyc + 2;
        expect_pulse(e + 1, c_p_short, "short_min");
        evt_at(1'b0, e);
        evt_at(1'b1, e + 1);
        wait_to(cyc + 10);
`endif

        wait_to(cyc + 20);
        check("sb_empty", sb.size(), 0);
        check("final_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
